// File: rtl/leiwand_rv32_wb_ram.sv
// rtl/leiwand_rv32_wb_ram.sv - pipelined Wishbone-B4 slave RAM with per-byte selects and clear-on-reset
//
// Purpose:
//   Single-port word RAM behind a pipelined Wishbone-B4 slave interface.
//   After reset an optional sequencer zeroes the array one word per cycle.
//   While it runs, requests are stalled. Afterwards one request is accepted per clock,
//   and each accepted request is acked exactly one cycle later.
//
// Ports:
//   i_clk    clock, all logic on posedge
//   i_rst    synchronous reset, active-high
//   i_cyc    Wishbone cycle valid
//   i_stb    Wishbone strobe / request valid
//   i_we     1 = write, 0 = read
//   i_addr   word address
//   i_sel    byte lane enables
//   i_dat    write data
//   o_dat    read data; zero whenever o_ack is low and for write acks
//   o_ack    one-cycle pulse per accepted request
//   o_stall  request not accepted this cycle (registered)
//   o_ready  clear sequence done, RAM serving requests

module leiwand_rv32_wb_ram #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_SIZE       = 1024,
    parameter int ADDR_WIDTH     = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1,
    parameter int SEL_WIDTH      = DATA_WIDTH / 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cyc,
    input  logic                  i_stb,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [SEL_WIDTH-1:0]  i_sel,
    input  logic [DATA_WIDTH-1:0] i_dat,
    output logic [DATA_WIDTH-1:0] o_dat,
    output logic                  o_ack,
    output logic                  o_stall,
    output logic                  o_ready
);

    // Width needed to index every word of the array; i_addr may be wider so
    // that out-of-range addresses can be presented and rejected.
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(MEM_SIZE - 1);
    localparam logic [ADDR_WIDTH:0] SIZE_EXT = (ADDR_WIDTH + 1)'(MEM_SIZE);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       clr_idx;
    logic [DATA_WIDTH-1:0]  mem [0:MEM_SIZE-1];

    logic                   accept;
    logic                   in_range;
    logic [IDX_W-1:0]       word_idx;

    assign accept   = i_cyc & i_stb & ~o_stall;
    // Compare with one extra bit so MEM_SIZE itself is representable.
    assign in_range = ({1'b0, i_addr} < SIZE_EXT);
    assign word_idx = i_addr[IDX_W-1:0];

    // Control FSM with registered handshake outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_idx <= '0;
            o_ack   <= 1'b0;
            o_dat   <= '0;
            o_stall <= 1'b1;
            o_ready <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    o_ack   <= 1'b0;
                    o_dat   <= '0;
                    if (clr_idx == LAST_IDX) begin
                        state   <= ST_RUN;
                        o_stall <= 1'b0;
                        o_ready <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                        o_stall <= 1'b1;
                        o_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    o_stall <= 1'b0;
                    o_ready <= 1'b1;
                    o_ack   <= accept;
                    // Read data is the pre-edge array content; write acks and
                    // out-of-range reads return zero.
                    if (accept && !i_we && in_range) begin
                        o_dat <= mem[word_idx];
                    end else begin
                        o_dat <= '0;
                    end
                end
                default: begin
                    state   <= ST_RUN;
                    o_ack   <= 1'b0;
                    o_dat   <= '0;
                    o_stall <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

    // Storage: one write port shared by the clear sequencer and bus writes.
    // Reset itself never modifies the array.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (state == ST_CLEAR) begin
                mem[clr_idx] <= '0;
            end else if (accept && i_we && in_range) begin
                for (int k = 0; k < SEL_WIDTH; k++) begin
                    if (i_sel[k]) begin
                        mem[word_idx][8*k +: 8] <= i_dat[8*k +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_leiwand_rv32_wb_ram.sv
// tb/tb_leiwand_rv32_wb_ram.sv - directed self-checking bench for leiwand_rv32_wb_ram

module tb_leiwand_rv32_wb_ram;

    localparam int DW = 32;
    localparam int MS = 16;
    localparam int AW = 5;
    localparam int SW = DW / 8;

    logic          i_clk;
    logic          i_rst;
    logic          i_cyc;
    logic          i_stb;
    logic          i_we;
    logic [AW-1:0] i_addr;
    logic [SW-1:0] i_sel;
    logic [DW-1:0] i_dat;
    logic [DW-1:0] o_dat;
    logic          o_ack;
    logic          o_stall;
    logic          o_ready;

    int checks = 0;
    int errors = 0;

    leiwand_rv32_wb_ram #(
        .DATA_WIDTH    (DW),
        .MEM_SIZE      (MS),
        .ADDR_WIDTH    (AW),
        .SEL_WIDTH     (SW),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_cyc  (i_cyc),
        .i_stb  (i_stb),
        .i_we   (i_we),
        .i_addr (i_addr),
        .i_sel  (i_sel),
        .i_dat  (i_dat),
        .o_dat  (o_dat),
        .o_ack  (o_ack),
        .o_stall(o_stall),
        .o_ready(o_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [AW-1:0] addr, input logic [SW-1:0] sel,
                       input logic [DW-1:0] dat);
        i_cyc  = 1'b1;
        i_stb  = 1'b1;
        i_we   = we;
        i_addr = addr;
        i_sel  = sel;
        i_dat  = dat;
    endtask

    task automatic idle();
        i_cyc  = 1'b0;
        i_stb  = 1'b0;
        i_we   = 1'b0;
        i_addr = '0;
        i_sel  = '0;
        i_dat  = '0;
    endtask

    // Counts sampled cycles with o_stall=1 until the RAM reports ready,
    // and notes any ack seen meanwhile (requests may be held during this).
    task automatic wait_ready(input string tag);
        int n;
        logic ack_seen;
        n = 0;
        ack_seen = 1'b0;
        while (o_stall && n < 64) begin
            if (o_ack || o_ready) ack_seen = 1'b1;
            n++;
            step();
        end
        chk({tag, "_stall_cycles"}, 32'(n), 32'd16);
        chk({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
        chk({tag, "_no_ack_or_ready_in_clear"}, {31'd0, ack_seen}, 32'd0);
    endtask

    initial begin
        idle();
        i_rst = 1'b1;

        // 1. reset, clear length, all words zero
        step();
        chk("rst_stall", {31'd0, o_stall}, 32'd1);
        chk("rst_ready", {31'd0, o_ready}, 32'd0);
        chk("rst_ack",   {31'd0, o_ack},   32'd0);
        chk("rst_dat",   o_dat,            32'd0);
        i_rst = 1'b0;
        wait_ready("clear1");
        for (int a = 0; a < MS; a++) begin
            req(1'b0, AW'(a), 4'hF, 32'hFFFF_FFFF);
            step();
            chk($sformatf("zero_ack_%0d", a), {31'd0, o_ack}, 32'd1);
            chk($sformatf("zero_dat_%0d", a), o_dat, 32'd0);
        end
        idle();
        step();
        chk("idle_ack", {31'd0, o_ack}, 32'd0);

        // 2. write then read same address on the next cycle
        req(1'b1, 5'd3, 4'hF, 32'hDEAD_BEEF);
        step();
        chk("t2_wr_ack", {31'd0, o_ack}, 32'd1);
        chk("t2_wr_dat", o_dat, 32'd0);
        req(1'b0, 5'd3, 4'h0, 32'h0);
        step();
        chk("t2_rd_ack", {31'd0, o_ack}, 32'd1);
        chk("t2_rd_dat", o_dat, 32'hDEAD_BEEF);
        idle();
        step();
        chk("t2_idle_ack", {31'd0, o_ack}, 32'd0);
        chk("t2_idle_dat", o_dat, 32'd0);

        // 3. partial byte write, then sel=0 write that must change nothing
        req(1'b1, 5'd5, 4'hF, 32'h1122_3344);
        step();
        req(1'b1, 5'd5, 4'h5, 32'hAABB_CCDD);
        step();
        req(1'b0, 5'd5, 4'h0, 32'h0);
        step();
        chk("t3_rd_dat", o_dat, 32'h11BB_33DD);
        req(1'b1, 5'd5, 4'h0, 32'hFFFF_FFFF);
        step();
        chk("t3_sel0_ack", {31'd0, o_ack}, 32'd1);
        req(1'b0, 5'd5, 4'hF, 32'h0);
        step();
        chk("t3_sel0_dat", o_dat, 32'h11BB_33DD);

        // 4. preload 0..7 and stream 8 back-to-back reads
        for (int a = 0; a < 8; a++) begin
            req(1'b1, AW'(a), 4'hF, 32'(a) * 32'h0101_0101);
            step();
        end
        for (int a = 0; a < 8; a++) begin
            chk($sformatf("t4_stall_%0d", a), {31'd0, o_stall}, 32'd0);
            req(1'b0, AW'(a), 4'h0, 32'h0);
            step();
            chk($sformatf("t4_ack_%0d", a), {31'd0, o_ack}, 32'd1);
            chk($sformatf("t4_dat_%0d", a), o_dat, 32'(a) * 32'h0101_0101);
        end
        // Master drops cyc right after the last read; its ack still arrives above.
        idle();
        step();
        chk("t4_tail_ack", {31'd0, o_ack}, 32'd0);

        // 5. out-of-range write/read, no wrap onto addr 4
        req(1'b1, 5'd20, 4'hF, 32'h1234_5678);
        step();
        chk("t5_wr_ack", {31'd0, o_ack}, 32'd1);
        chk("t5_wr_stall", {31'd0, o_stall}, 32'd0);
        req(1'b0, 5'd20, 4'hF, 32'h0);
        step();
        chk("t5_rd20_ack", {31'd0, o_ack}, 32'd1);
        chk("t5_rd20_dat", o_dat, 32'd0);
        req(1'b0, 5'd4, 4'hF, 32'h0);
        step();
        chk("t5_rd4_ack", {31'd0, o_ack}, 32'd1);
        chk("t5_rd4_dat", o_dat, 32'h0404_0404);
        idle();
        step();

        // 6. reset in cycle 5 of clear restarts it; requests held during clear
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        req(1'b1, 5'd6, 4'hF, 32'hCAFE_F00D);
        for (int c = 0; c < 4; c++) step();
        chk("t6_mid_clear_stall", {31'd0, o_stall}, 32'd1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("t6_rerst_ready", {31'd0, o_ready}, 32'd0);
        wait_ready("clear2");
        req(1'b0, 5'd3, 4'hF, 32'h0);
        step();
        chk("t6_cleared3_ack", {31'd0, o_ack}, 32'd1);
        chk("t6_cleared3_dat", o_dat, 32'd0);
        req(1'b0, 5'd7, 4'hF, 32'h0);
        step();
        chk("t6_cleared7_dat", o_dat, 32'd0);

        // read accepted in the reset cycle produces no ack
        req(1'b0, 5'd2, 4'hF, 32'h0);
        i_rst = 1'b1;
        step();
        chk("t6_rst_ack", {31'd0, o_ack}, 32'd0);
        chk("t6_rst_dat", o_dat, 32'd0);
        chk("t6_rst_stall", {31'd0, o_stall}, 32'd1);
        i_rst = 1'b0;
        idle();
        step();
        chk("t6_post_ack", {31'd0, o_ack}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
